core_insn_loader: RTL
=====================

Name: core_insn_loader

Overview:
- Per-core front end directly downstream of the task scheduler; one instance per core.
- Captures one instruction frame from the scheduler's multi-cycle load bus into a local frame buffer, and latches this core's initial R0.
- Releases the core to execute the captured frame.
- Drives the core's Ready bit back to the scheduler: high while idle or loading, low while a frame is executing.

Parameters:
- INSN_LOAD_TIME, 4, bus cycles per frame (parts 0..INSN_LOAD_TIME-1).
- PART_W, 64, Insn_Data width per part.
- INSN_W, 16, instruction width; PART_W must be a multiple of INSN_W.
- REG_W, 8, R0 width.
- CNT_W, 2, Insn_Load_Counter width; must satisfy 2^CNT_W >= INSN_LOAD_TIME.
- Derived: FRAME_INSNS = INSN_LOAD_TIME*PART_W/INSN_W (16); PC_W = clog2(FRAME_INSNS).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  this core's bit of the scheduler Start vector.
- Insn_Load_Counter  in  CNT_W  index of the part on Insn_Data.
- Insn_Data  in  PART_W  frame part.
- Init_R0_Vect  in  1  this core's R0-init enable.
- Init_R0  in  REG_W  this core's R0 slice.
- Ready  out  1  to scheduler; 1 = idle or able to accept parts.
- core_pc  in  PC_W  core fetch index into the frame.
- core_insn  out  INSN_W  fetched instruction.
- core_go  out  1  one-cycle pulse: frame valid, begin execution at pc 0.
- core_done  in  1  core finished the current frame.
- r0_load  out  1  one-cycle pulse, coincident with core_go, when R0 init is requested.
- r0_value  out  REG_W  R0 value, valid with r0_load.
- proto_err  out  1  sticky load-protocol violation flag.

Behaviour:
- Reset values (asynchronous, on reset low): state IDLE, Ready=1, core_go=0, r0_load=0, r0_value=0, proto_err=0, expected part=0, part-valid bits cleared. Buffer contents are not reset.
- State IDLE, Ready=1:
  - Start with counter 0: write part 0, expected part=1, go to LOAD.
  - Start with counter != 0: discard the part, set proto_err, stay in IDLE.
- State LOAD, Ready=1:
  - Start with counter == expected part: write that part into buffer slot counter.
  - If counter == INSN_LOAD_TIME-1: latch Init_R0_Vect and Init_R0, go to GO.
  - Otherwise expected part += 1.
  - Start with counter != expected part: set proto_err. If counter==0, restart the load at part 0; otherwise discard and return to IDLE.
  - Start low in LOAD: hold state; gaps between parts are legal.
- State GO, one cycle:
  - Ready=0, core_go=1.
  - r0_load=latched enable; r0_value=latched R0.
  - Go to EXEC.
- State EXEC, Ready=0:
  - On core_done: go to IDLE; Ready=1 on the next cycle.
  - Start in EXEC: ignored, set proto_err.
- Ready falls the cycle after the final part is written, so the scheduler sees Ready low before it can issue the next frame's Start.
- core_done outside EXEC is ignored.
- Buffer write: a part occupies instructions [counter*PART_W/INSN_W +: PART_W/INSN_W]; the low INSN_W bits of a part hold the lowest-index instruction.
- core_insn is a combinational read at core_pc. It returns 0 unless a complete frame is valid (GO or EXEC state).
- Simultaneous Start and core_done in EXEC: core_done wins, Start is ignored, proto_err is set.
- Reset mid-load: the partial frame is dropped and the next load must begin at part 0.

Optional Feature:
- Macro: CORE_INSN_LOADER_DBL_BUF_EN.
- Defined:
  - Two frame banks.
  - Ready returns to 1 one cycle after core_go, so the next frame can load into the inactive bank while the core executes.
  - A second completed frame waits in a PEND state until core_done.
  - core_go for the pending frame fires the cycle after core_done, and the banks swap at that point.
  - Ready is 0 while a frame is pending.
- Undefined: single bank, behaviour exactly as above.

Decomposition:
- Shared package: INSN_LOAD_TIME, PART_W, INSN_W, REG_W, CNT_W, derived FRAME_INSNS/PC_W, and the state encoding (IDLE, LOAD, GO, EXEC, PEND).
- One sub-module: core_frame_buf. It holds the bank(s) with a part-granular write port and an instruction-granular combinational read port, selected by bank.

Test Plan:
- Load parts 0..3 with Insn_Data=64'h0001_0002_0003_0004, +1 per part, then pulse core_done -> core_go one cycle after part 3. core_pc=0 gives 16'h0004 and core_pc=15 gives 16'h0004 (part 3 = 64'h0004_0005_0006_0007, top instruction 16'h0004). Ready=0 until one cycle after core_done.
- Init_R0_Vect=1, Init_R0=8'hA5 at part 3 -> r0_load=1 and r0_value=8'hA5 coincident with core_go. With Init_R0_Vect=0: r0_load stays 0.
- Part sequence 0,2 -> proto_err=1, state IDLE, Ready=1, core_go never pulses; a fresh 0..3 sequence then completes normally.
- Parts 0,1 then a 5-cycle Start gap, then parts 2,3 -> frame accepted and core_go fires.
- Assert reset low during part 2 -> all outputs return to their reset values immediately; a subsequent part-1 Start sets proto_err.
- With CORE_INSN_LOADER_DBL_BUF_EN: frame A executes while frame B loads (Ready=1). When B completes, Ready=0 (PEND). core_done for A -> core_go for B next cycle, and core_insn reads B's data.

Source files
------------

// File: rtl/core_insn_loader_pkg.sv
// Shared constants and state encoding for the per-core instruction loader.
// Optional build macro CORE_INSN_LOADER_DBL_BUF_EN selects two frame banks.
package core_insn_loader_pkg;

  // Load bus geometry
  localparam int INSN_LOAD_TIME = 4;
  localparam int PART_W         = 64;
  localparam int INSN_W         = 16;
  localparam int REG_W          = 8;
  localparam int CNT_W          = 2;

  // Derived frame geometry
  localparam int FRAME_INSNS    = INSN_LOAD_TIME * PART_W / INSN_W;
  localparam int PC_W           = $clog2(FRAME_INSNS);
  localparam int FRAME_W        = FRAME_INSNS * INSN_W;

`ifdef CORE_INSN_LOADER_DBL_BUF_EN
  localparam int NUM_BANKS      = 2;
`else
  localparam int NUM_BANKS      = 1;
`endif

  // Index of the part that completes a frame
  localparam logic [CNT_W-1:0] LAST_PART = CNT_W'(INSN_LOAD_TIME - 1);

  // Loader states; PEND is only reachable with two banks
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_GO   = 3'd2,
    ST_EXEC = 3'd3,
    ST_PEND = 3'd4
  } state_t;

  // One-hot mask for a part index
  function automatic logic [INSN_LOAD_TIME-1:0] part_bit(input logic [CNT_W-1:0] idx);
    logic [INSN_LOAD_TIME-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/core_frame_buf.sv
// Frame buffer: part-granular write port, instruction-granular combinational
// read port, one or two banks. Instruction i of a bank lives at bits
// [i*INSN_W +: INSN_W], so a part's low INSN_W bits land on its lowest index.
// Contents are deliberately not reset.
module core_frame_buf
  import core_insn_loader_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [CNT_W-1:0]  wr_part,
  input  logic [PART_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [PC_W-1:0]   rd_pc,
  output logic [INSN_W-1:0] rd_insn
);

  logic [NUM_BANKS*FRAME_W-1:0] frame_q;
  logic [NUM_BANKS*FRAME_W-1:0] frame_d;
  int                           wr_off;
  int                           rd_off;

  // Bit offsets of the write part and the read instruction
  always_comb begin
    wr_off = ((NUM_BANKS > 1) ? int'(wr_bank) : 0) * FRAME_W + int'(wr_part) * PART_W;
    rd_off = ((NUM_BANKS > 1) ? int'(rd_bank) : 0) * FRAME_W + int'(rd_pc) * INSN_W;
  end

  // Next buffer contents: merge the incoming part into its slot
  always_comb begin
    frame_d = frame_q;
    if (wr_en) begin
      frame_d[wr_off +: PART_W] = wr_data;
    end
  end

  // Storage register, no reset
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  // Combinational fetch
  always_comb begin
    rd_insn = frame_q[rd_off +: INSN_W];
  end

endmodule

// File: rtl/core_insn_loader.sv
// Per-core instruction loader: captures one frame from the scheduler's
// multi-cycle load bus, latches the initial R0, releases the core with a
// one-cycle core_go and drives Ready back to the scheduler.
// Optional build macro CORE_INSN_LOADER_DBL_BUF_EN: two banks, the next frame
// may load while the current one executes and then waits in PEND.
//
// Handshake: the scheduler may present a part (Start=1) only while Ready=1;
// each such cycle transfers exactly one part. Start while Ready=0 is a
// protocol violation, ignored and recorded in the sticky proto_err.
module core_insn_loader
  import core_insn_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Insn_Load_Counter,
  input  logic [PART_W-1:0] Insn_Data,
  input  logic              Init_R0_Vect,
  input  logic [REG_W-1:0]  Init_R0,
  output logic              Ready,
  input  logic [PC_W-1:0]   core_pc,
  output logic [INSN_W-1:0] core_insn,
  output logic              core_go,
  input  logic              core_done,
  output logic              r0_load,
  output logic [REG_W-1:0]  r0_value,
  output logic              proto_err,
  output logic [2:0]        dbg_state
);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          exp_q, exp_d;
  logic [INSN_LOAD_TIME-1:0] part_vld_q, part_vld_d;
  logic                      r0_en_q, r0_en_d;
  logic [REG_W-1:0]          r0_q, r0_d;
  logic                      err_q, err_d;

  logic                      in_load;
  logic                      load_ok;
  logic                      take;
  logic                      restart;
  logic                      buf_wr;
  logic                      act_bank;
  logic                      wr_bank;
  logic                      frame_valid;
  logic [INSN_W-1:0]         buf_insn;

  // A load is in progress once part 0 has been accepted
  assign in_load = |part_vld_q;

`ifdef CORE_INSN_LOADER_DBL_BUF_EN
  logic bank_q, bank_d;

  // Banks swap whenever a completed frame is released to the core
  always_comb begin
    bank_d = bank_q;
    if (state_d == ST_GO && state_q != ST_GO) begin
      bank_d = ~bank_q;
    end
  end

  // Active bank register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign act_bank = bank_q;
  assign wr_bank  = ~bank_q;
`else
  assign act_bank = 1'b0;
  assign wr_bank  = 1'b0;
`endif

  // Next-state logic: execution control plus part acceptance
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    part_vld_d = part_vld_q;
    r0_en_d    = r0_en_q;
    r0_d       = r0_q;
    err_d      = err_q;
    load_ok    = 1'b0;
    take       = 1'b0;
    restart    = 1'b0;
    buf_wr     = 1'b0;

    // Which states hand Start to the part acceptor
    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        load_ok = Start;
      end
      ST_GO: begin
        state_d = ST_EXEC;
        if (Start) err_d = 1'b1;
      end
      ST_EXEC: begin
        if (core_done) begin
          // core_done wins over a simultaneous Start
          state_d = in_load ? ST_LOAD : ST_IDLE;
          if (Start) err_d = 1'b1;
        end else if (Start) begin
`ifdef CORE_INSN_LOADER_DBL_BUF_EN
          load_ok = 1'b1;
`else
          err_d   = 1'b1;
`endif
        end
      end
      ST_PEND: begin
        if (core_done) state_d = ST_GO;
        if (Start) err_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Part acceptance: in-order parts, restart on part 0, abandon otherwise
    if (load_ok) begin
      if (in_load && Insn_Load_Counter == exp_q) begin
        take = 1'b1;
      end else if (Insn_Load_Counter == '0) begin
        take    = 1'b1;
        restart = 1'b1;
        if (in_load) err_d = 1'b1;
      end else begin
        err_d = 1'b1;
        if (in_load) begin
          part_vld_d = '0;
          exp_d      = '0;
          if (state_q == ST_LOAD) state_d = ST_IDLE;
        end
      end

      if (take) begin
        buf_wr = 1'b1;
        if (Insn_Load_Counter == LAST_PART) begin
          part_vld_d = '0;
          exp_d      = '0;
          r0_en_d    = Init_R0_Vect;
          r0_d       = Init_R0;
          state_d    = (state_q == ST_EXEC) ? ST_PEND : ST_GO;
        end else begin
          part_vld_d = (restart ? '0 : part_vld_q) | part_bit(Insn_Load_Counter);
          exp_d      = Insn_Load_Counter + 1'b1;
          if (state_q == ST_IDLE) state_d = ST_LOAD;
        end
      end
    end
  end

  // State and protocol registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      exp_q      <= '0;
      part_vld_q <= '0;
      r0_en_q    <= 1'b0;
      r0_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      part_vld_q <= part_vld_d;
      r0_en_q    <= r0_en_d;
      r0_q       <= r0_d;
      err_q      <= err_d;
    end
  end

  // Ready: accept parts while idle/loading (and executing with two banks)
  always_comb begin
    Ready = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_LOAD: Ready = 1'b1;
`ifdef CORE_INSN_LOADER_DBL_BUF_EN
      ST_EXEC:          Ready = 1'b1;
`else
      ST_EXEC:          Ready = 1'b0;
`endif
      ST_GO, ST_PEND:   Ready = 1'b0;
      default:          Ready = 1'b0;
    endcase
  end

  // Core-facing outputs; fetches read zero unless a complete frame is live
  always_comb begin
    frame_valid = (state_q == ST_GO) || (state_q == ST_EXEC) || (state_q == ST_PEND);
    core_insn   = frame_valid ? buf_insn : '0;
    core_go     = (state_q == ST_GO);
    r0_load     = (state_q == ST_GO) && r0_en_q;
    r0_value    = r0_q;
    proto_err   = err_q;
    dbg_state   = state_q;
  end

  core_frame_buf u_frame_buf (
    .clk     (clk),
    .wr_en   (buf_wr),
    .wr_bank (wr_bank),
    .wr_part (Insn_Load_Counter),
    .wr_data (Insn_Data),
    .rd_bank (act_bank),
    .rd_pc   (core_pc),
    .rd_insn (buf_insn)
  );

endmodule
